// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXECUTE sequencer strobing IR, PC, ACC, memory and flags enables
module control_unit #(
  parameter int OPCODE_WIDTH = 5,
  parameter bit CLEAR_FLAGS_ON_RESET = 1'b1
) (
  input  logic                    clock,
  input  logic                    control_reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  input  logic                    flag_Z,
  input  logic                    flag_N,
  output logic                    ir_wr,
  output logic                    pc_wr,
  output logic                    pc_src,
  output logic                    acc_wr,
  output logic                    flags_wr,
  output logic                    flags_clear,
  output logic                    mem_wr,
  output logic                    operand_sel,
  output logic [1:0]              alu_op,
  output logic                    branch_taken,
  output logic                    halted
);
  typedef enum logic [2:0] {INIT, FETCH, DECODE, EXECUTE, HALT} state_t;
  state_t state;
  logic [3:0] op;
  logic go, dec, ex, done, bt;
  always_ff @(posedge clock)
    if (control_reset) state <= CLEAR_FLAGS_ON_RESET ? INIT : FETCH;
    else state <= state == INIT    ? FETCH :
                  state == FETCH   ? (mem_ready ? DECODE : FETCH) :
                  state == DECODE  ? (op == 4'h0 ? HALT : EXECUTE) :
                  state == EXECUTE ? (done ? FETCH : EXECUTE) : HALT;
  always_comb begin
    go = !control_reset;
    op = |(opcode >> 4) ? 4'hF : opcode[3:0];
    dec = go && state == DECODE;
    ex = go && state == EXECUTE;
    done = (op == 4'h1 || op == 4'h2) ? mem_ready : 1'b1;
    bt = op == 4'h8 ? flag_Z :
         op == 4'h9 ? !flag_Z :
         op == 4'hA ? !flag_Z && !flag_N :
         op == 4'hB ? !flag_N :
         op == 4'hC ? flag_N :
         op == 4'hD ? flag_Z || flag_N : op == 4'hE;
    branch_taken = (dec || ex) && bt;
    ir_wr = go && state == FETCH && mem_ready;
    pc_wr = ex && done;
    pc_src = pc_wr && bt;
    acc_wr = pc_wr && op >= 4'h2 && op <= 4'h7;
    flags_wr = acc_wr;
    flags_clear = go && state == INIT;
    mem_wr = ex && op == 4'h1;
    operand_sel = (dec || ex) && (op == 4'h3 || op == 4'h5 || op == 4'h7);
    alu_op = !(dec || ex) ? 2'b00 :
             (op == 4'h4 || op == 4'h5) ? 2'b01 :
             (op == 4'h6 || op == 4'h7) ? 2'b10 : 2'b00;
    halted = go && state == HALT;
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit
module tb_control_unit;
  logic clock = 1'b0, control_reset = 1'b1, mem_ready = 1'b1, flag_Z = 1'b0, flag_N = 1'b0;
  logic [4:0] opcode = 5'h3;
  logic ir_wr, pc_wr, pc_src, acc_wr, flags_wr, flags_clear, mem_wr, operand_sel, branch_taken, halted;
  logic [1:0] alu_op;
  logic [11:0] outs;
  int n = 0, f = 0;
  localparam logic [11:0] IR = 12'h800, PC = 12'h400, SRC = 12'h200, ACC = 12'h100, FW = 12'h080,
                          FC = 12'h040, MW = 12'h020, OS = 12'h010, SUB = 12'h008, ADD = 12'h004,
                          BT = 12'h002, H = 12'h001;
  control_unit dut (
    .clock(clock), .control_reset(control_reset), .opcode(opcode), .mem_ready(mem_ready),
    .flag_Z(flag_Z), .flag_N(flag_N), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src),
    .acc_wr(acc_wr), .flags_wr(flags_wr), .flags_clear(flags_clear), .mem_wr(mem_wr),
    .operand_sel(operand_sel), .alu_op(alu_op), .branch_taken(branch_taken), .halted(halted)
  );
  assign outs = {ir_wr, pc_wr, pc_src, acc_wr, flags_wr, flags_clear, mem_wr, operand_sel, alu_op, branch_taken, halted};
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n++;
    if (got !== exp) begin
      f++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic instr(input logic [4:0] opc, input logic z, input logic nf, input logic [11:0] d, input logic [11:0] x);
    opcode = opc;
    flag_Z = z;
    flag_N = nf;
    #1 chk("fetch", outs, IR);
    tick;
    #1 chk("decode", outs, d);
    tick;
    #1 chk("execute", outs, x);
    tick;
  endtask
  initial begin
    #1 chk("reset", outs, 12'h000);
    tick;
    control_reset = 1'b0;
    #1 chk("init", outs, FC);
    tick;
    instr(5'h03, 0, 0, OS, PC | ACC | FW | OS);
    instr(5'h07, 0, 0, OS | SUB, PC | ACC | FW | OS | SUB);
    instr(5'h04, 0, 0, ADD, PC | ACC | FW | ADD);
    instr(5'h08, 1, 0, BT, PC | SRC | BT);
    instr(5'h09, 1, 0, 12'h000, PC);
    instr(5'h0D, 1, 0, BT, PC | SRC | BT);
    instr(5'h0A, 1, 0, 12'h000, PC);
    instr(5'h0C, 0, 1, BT, PC | SRC | BT);
    instr(5'h0B, 0, 1, 12'h000, PC);
    instr(5'h0A, 0, 1, 12'h000, PC);
    instr(5'h0D, 0, 1, BT, PC | SRC | BT);
    instr(5'h0A, 0, 0, BT, PC | SRC | BT);
    instr(5'h0E, 0, 0, BT, PC | SRC | BT);
    instr(5'h18, 1, 0, 12'h000, PC);
    opcode = 5'h02;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("fetch_wait", outs, 12'h000);
      tick;
    end
    mem_ready = 1'b1;
    #1 chk("fetch_done", outs, IR);
    tick;
    #1 chk("ld_decode", outs, 12'h000);
    tick;
    #1 chk("ld_exec", outs, PC | ACC | FW);
    tick;
    opcode = 5'h01;
    #1 chk("sto_fetch", outs, IR);
    tick;
    #1 chk("sto_decode", outs, 12'h000);
    tick;
    mem_ready = 1'b0;
    #1 chk("sto_wait1", outs, MW);
    tick;
    #1 chk("sto_wait2", outs, MW);
    tick;
    mem_ready = 1'b1;
    #1 chk("sto_done", outs, MW | PC);
    tick;
    instr(5'h00, 0, 0, 12'h000, H);
    for (int i = 0; i < 10; i++) begin
      opcode = 5'(i * 3);
      mem_ready = i[0];
      #1 chk("halt_hold", outs, H);
      tick;
    end
    control_reset = 1'b1;
    #1 chk("halt_reset", outs, 12'h000);
    tick;
    control_reset = 1'b0;
    mem_ready = 1'b1;
    #1 chk("halt_reinit", outs, FC);
    tick;
    opcode = 5'h02;
    #1 chk("ld2_fetch", outs, IR);
    tick;
    #1 chk("ld2_decode", outs, 12'h000);
    tick;
    mem_ready = 1'b0;
    #1 chk("ld2_wait", outs, 12'h000);
    control_reset = 1'b1;
    #1 chk("ld2_reset", outs, 12'h000);
    tick;
    control_reset = 1'b0;
    #1 chk("ld2_reinit", outs, FC);
    tick;
    mem_ready = 1'b1;
    #1 chk("post_fetch", outs, IR);
    $display("End of test - %0d assertions evaluated, %0d failures", n, f);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle instruction sequencer for the accumulator processor. It steps each instruction through FETCH, DECODE and EXECUTE. It strobes the IR, PC, accumulator, memory and flags-register write enables. It resolves conditional branches from the registered flag_Z/flag_N produced by the flags block. It also owns clearing the flags register after reset.

Parameters:
OPCODE_WIDTH, 5, width of opcode input; bits above bit 3 must be 0 for a defined opcode, otherwise the instruction is treated as NOP
CLEAR_FLAGS_ON_RESET, 1, 1 = spend one INIT cycle pulsing flags_clear after reset; 0 = go straight to FETCH

Ports:
clock  input  1  system clock, all state changes on rising edge
control_reset  input  1  synchronous, active-high reset
opcode  input  OPCODE_WIDTH  opcode field of the instruction register
mem_ready  input  1  memory handshake; 1 = current fetch/load/store access completes this cycle
flag_Z  input  1  registered zero flag from flags block
flag_N  input  1  registered negative flag from flags block
ir_wr  output  1  load instruction register
pc_wr  output  1  load program counter
pc_src  output  1  0 = PC+1, 1 = branch target (operand field)
acc_wr  output  1  load accumulator
flags_wr  output  1  write enable to flags block
flags_clear  output  1  reset strobe to flags block
mem_wr  output  1  data memory write
operand_sel  output  1  0 = memory operand, 1 = immediate
alu_op  output  2  00 PASS, 01 ADD, 10 SUB, 11 unused (never driven)
branch_taken  output  1  branch condition result for current opcode
halted  output  1  processor stopped

Behaviour:
- One clock; reset is synchronous and active-high on control_reset, sampled on the rising edge of clock. It overrides every other input, including mid-instruction and while halted.
- Opcodes:
  - 0 HLT; 1 STO; 2 LD; 3 LDI; 4 ADD; 5 ADDI; 6 SUB; 7 SUBI.
  - 8 BEQ; 9 BNE; A BGT; B BGE; C BLT; D BLE; E JMP; F NOP.
  - Any other value is NOP.
- States: INIT, FETCH, DECODE, EXECUTE, HALT. All strobes are registered-state decodes (Moore), except that the mem_ready qualifier is combinational.
- After reset: state = INIT if CLEAR_FLAGS_ON_RESET=1, else FETCH. All outputs are 0 during the reset cycle.
- INIT: flags_clear=1 for exactly one cycle -> FETCH.
- FETCH: waits while mem_ready=0 with all strobes 0. In the cycle mem_ready=1, ir_wr=1 -> DECODE. There is no timeout.
- DECODE: no strobes. alu_op and operand_sel reflect the opcode. Next state is HALT if opcode=HLT, else EXECUTE.
- EXECUTE, per opcode:
  - LD/LDI/ADD/ADDI/SUB/SUBI: acc_wr=1 and flags_wr=1 in the same cycle. alu_op is PASS/PASS/ADD/ADD/SUB/SUB. operand_sel=1 for LDI/ADDI/SUBI.
  - LD only: wait in EXECUTE while mem_ready=0. acc_wr, flags_wr and pc_wr are asserted only in the mem_ready=1 cycle.
  - STO: wait for mem_ready. mem_wr=1 in every EXECUTE cycle until the mem_ready=1 cycle, inclusive.
  - Branches use the flag_Z/flag_N values present in EXECUTE:
    - BEQ=Z; BNE=!Z; BLT=N; BGE=!N.
    - BGT=!Z&!N; BLE=Z|N; JMP=1.
    - Non-branch opcodes: branch_taken=0.
  - Every instruction's completing EXECUTE cycle asserts pc_wr=1 with pc_src=branch_taken -> FETCH.
- Instruction latency: 3 cycles with mem_ready held 1. Each mem_ready=0 cycle adds one cycle.
- Flag freshness: flags_wr in instruction n's EXECUTE is visible as flag_Z/flag_N by instruction n+1's EXECUTE. No interlock is needed.
- flags_wr and flags_clear are never asserted together.
- HALT: halted=1, all strobes 0. Stays until control_reset, regardless of opcode or mem_ready.
- branch_taken is valid in DECODE and EXECUTE and is 0 in other states.

Test Plan:
1. Reset with CLEAR_FLAGS_ON_RESET=1, mem_ready=1 -> cycle 1 flags_clear=1; cycle 2 FETCH with ir_wr=1; all other outputs 0.
2. LDI (3) then SUBI (7), mem_ready=1 -> each completes in 3 cycles. flags_wr=1 and acc_wr=1 in the EXECUTE cycle; alu_op=00 then 10; operand_sel=1; pc_wr=1, pc_src=0.
3. Branch sweep:
   - Z=1,N=0: BEQ taken, BNE not, BLE taken, BGT not.
   - Z=0,N=1: BLT taken, BGE not, BGT not, BLE taken.
   - JMP always pc_src=1.
4. FETCH with mem_ready=0 for 4 cycles then 1 -> ir_wr single pulse in cycle 5; no other strobes before it.
5. STO with mem_ready low 2 cycles -> mem_wr=1 for 3 cycles, pc_wr only in the third.
6. HLT -> halted=1 from the cycle after DECODE and stays for 10 cycles with varying opcode. Then control_reset=1 mid-HALT -> next cycle INIT and halted=0. Also assert control_reset during LD EXECUTE with mem_ready=0 -> no acc_wr/flags_wr, state returns to INIT.
